sha256_msg_ctrl: RTL and testbench
==================================

SHA256_MSG_CTRL -- requirements
Module: sha256_msg_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 32, giving the width of the message bit-length counter, zero-extended to 64 bits in the length field.
REQ-002 Ports SHALL be as follows:
- clk  in  1  the single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  8  message byte.
- valid  in  1  din is valid.
- last  in  1  din is the final message byte. With valid low in IDLE it requests an empty message.
- busy  out  1  a byte offered this cycle is not taken.
- blk_word  out  32  word sent to the core.
- blk_valid  out  1  blk_word is valid.
- blk_ready  in  1  the core accepts the word.
- blk_first  out  1  the current word belongs to the first block of the message.
- blk_last  out  1  word 15 of the final block.
- core_done  in  1  single-cycle pulse: the digest is ready.
- core_digest  in  256  the digest.
- dout  out  8  digest byte.
- dvalid  out  1  dout is valid.

Function
REQ-003 A byte SHALL be accepted when valid=1 and busy=0. Bytes SHALL be packed big-endian: the first byte goes to blk_word[31:24].
REQ-004 The state machine SHALL have these states: IDLE, ABSORB, PAD, LEN_HI, LEN_LO, WAIT_DIG, OUT.
REQ-005 Word transfer SHALL occur when blk_valid=1 and blk_ready=1. blk_word, blk_first and blk_last SHALL be held stable while blk_valid=1 and blk_ready=0.
REQ-006 busy SHALL be 1 whenever a packed word is pending, and in PAD, LEN_HI, LEN_LO, WAIT_DIG and OUT.
REQ-007 After the last byte, the block SHALL append byte 0x80 and then zero bytes up to word 13 of a block.
REQ-008 If the 0x80 byte lands in word 14 or 15, the block SHALL zero-fill to word 15, emit that block, and pad a further all-zero block up to word 13.
REQ-009 LEN_HI and LEN_LO SHALL emit the 64-bit bit length (bytes*8), high word first.
REQ-010 If the byte count exceeds the LEN_W capacity, the length SHALL wrap modulo 2^LEN_W.
REQ-011 A word-index counter (0-15) SHALL wrap to 0 after each word-15 transfer. blk_first SHALL clear after the first wrap.
REQ-012 In WAIT_DIG the block SHALL ignore valid and last. On core_done it SHALL capture core_digest and enter OUT on the next cycle.
REQ-013 In OUT, dvalid SHALL be 1 for exactly 32 consecutive cycles.
REQ-014 Byte k in OUT SHALL be core_digest[255-8k -: 8], with no stall.
REQ-015 After the 32nd byte the block SHALL return to IDLE and busy SHALL fall in the following cycle.
REQ-016 core_done outside WAIT_DIG SHALL be ignored.
REQ-017 last=1 with valid=0 outside IDLE SHALL be ignored. While a word is pending, valid and last SHALL be held by the source.
REQ-018 An empty message SHALL produce one block: 0x80000000, fourteen zero words (including LEN_HI), and then LEN_LO=0.

Reset
REQ-019 While rst_n=0 the outputs SHALL be: busy=0, blk_valid=0, blk_first=0, blk_last=0, blk_word=0, dvalid=0, dout=0.
REQ-020 While rst_n=0 all counters SHALL be 0 and the state SHALL be IDLE.
REQ-021 Reset asserted mid-message or mid-OUT SHALL abort immediately with no further blk_valid or dvalid. Release of reset SHALL be synchronised to clk.

Configuration
REQ-022 With SHA256_MSG_CTRL_ERR_EN defined, the block SHALL add output port err (1 bit).
REQ-023 err SHALL be a sticky flag, set when valid=1 while busy=1 in WAIT_DIG or OUT, or on length-counter overflow. It SHALL clear only on reset or on the next IDLE-to-ABSORB transition.
REQ-024 Without SHA256_MSG_CTRL_ERR_EN the err port SHALL be absent, and overflow SHALL wrap silently.

Structure
REQ-025 Package sha256_msg_ctrl_pkg SHALL hold the state enum, BLOCK_WORDS=16, DIGEST_BYTES=32, PAD_BYTE=8'h80 and LEN_WORD_IDX=14.
REQ-026 Sub-module sha256_digest_ser SHALL hold the 256-bit capture register, a 5-bit byte counter, dout and dvalid.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- "abc" (0x61,0x62,0x63, last on 0x63) -> words 0x61626380, 0x0×14, 0x00000018, blk_first=1 on all 16 words, blk_last on word 15; model core_done -> 32 dout bytes = ba7816bf…f20015ad.
- Empty message (last, valid=0 in IDLE) -> 0x80000000, then 15 zero words; model core_done -> dout e3b0c442…7852b855.
- 55-byte message -> exactly 1 block, word 13 = 0x??????80, LEN_LO=0x000001B8.
- 56-byte message -> 2 blocks; block 2 words 0-13 all zero and LEN_LO=0x000001C0; blk_first only on block 1.
- blk_ready held low 5 cycles at word 3 -> blk_word stable and busy=1 throughout, no byte lost.
- rst_n low during OUT at byte 10 -> dvalid=0 that cycle. A fresh "abc" after release -> correct digest.

Source files
------------

// File: rtl/sha256_msg_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message controller.
package sha256_msg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ABSORB   = 3'd1,
        PAD      = 3'd2,
        LEN_HI   = 3'd3,
        LEN_LO   = 3'd4,
        WAIT_DIG = 3'd5,
        OUT      = 3'd6
    } state_e;

    localparam int         BLOCK_WORDS  = 16;
    localparam int         DIGEST_BYTES = 32;
    localparam logic [7:0] PAD_BYTE     = 8'h80;
    localparam int         LEN_WORD_IDX = 14;

    // Big-endian byte lane insert: position 0 is bits [31:24].
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [7:0] b,
                                             input logic [1:0] pos);
        logic [31:0] r;
        r = w;
        case (pos)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r        = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_digest_ser.sv
// Captures the 256-bit digest and streams it out MSB byte first, one byte per cycle.
module sha256_digest_ser (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [255:0] i_digest,
    output logic [7:0]   o_dout,
    output logic         o_dvalid,
    output logic         o_last
);
    import sha256_msg_ctrl_pkg::*;

    logic [255:0] r_dig;
    logic [4:0]   r_cnt;
    logic         r_active;

    // Capture on load, then shift one byte per cycle until all bytes are out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dig    <= 256'h0;
            r_cnt    <= 5'd0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_dig    <= i_digest;
            r_cnt    <= 5'd0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_dig    <= {r_dig[247:0], 8'h00};
            r_cnt    <= r_cnt + 5'd1;
            r_active <= (r_cnt != 5'(DIGEST_BYTES - 1));
        end else begin
            r_active <= 1'b0;
        end
    end

    assign o_dout   = r_active ? r_dig[255:248] : 8'h00;
    assign o_dvalid = r_active;
    assign o_last   = r_active && (r_cnt == 5'(DIGEST_BYTES - 1));

endmodule

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message front end: byte packing, padding, length words and digest serialisation.
// Define SHA256_MSG_CTRL_ERR_EN to add the sticky err output.
module sha256_msg_ctrl
    import sha256_msg_ctrl_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   din,
    input  logic         valid,
    input  logic         last,
    output logic         busy,
    output logic [31:0]  blk_word,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic [7:0]   dout,
    output logic         dvalid
`ifdef SHA256_MSG_CTRL_ERR_EN
    ,
    output logic         err
`endif
);

    state_e           r_state, w_state_nxt;
    logic [1:0]       r_rst_sync;
    logic [31:0]      r_word, w_packed, w_blk_word;
    logic [1:0]       r_bpos;
    logic             r_pend, r_pad80, r_first;
    logic [3:0]       r_widx;
    logic [LEN_W-1:0] r_len, w_len_base, w_len_nxt;
    logic [63:0]      w_len64;
    logic             w_run, w_in_absorb, w_accept, w_empty, w_bv, w_xfer;
    logic             w_pad80_nxt, w_load, w_ser_last;

    // Reset release is re-timed to clk; assertion still acts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run       = r_rst_sync[1];
    assign w_in_absorb = (r_state == IDLE) || (r_state == ABSORB);
    assign w_accept    = w_run && w_in_absorb && !r_pend && valid;
    assign w_empty     = w_run && (r_state == IDLE) && !valid && last;
    assign w_bv        = r_pend || (r_state == PAD) || (r_state == LEN_HI) || (r_state == LEN_LO);
    assign w_xfer      = w_bv && blk_ready;
    // A PAD transfer without a pending data word always carries (or follows) the 0x80.
    assign w_pad80_nxt = r_pad80 || !r_pend;
    assign w_load      = w_run && (r_state == WAIT_DIG) && core_done;
    assign w_packed    = put_byte((r_bpos == 2'd0) ? 32'h0 : r_word, din, r_bpos);
    assign w_len_base  = (r_state == IDLE) ? {LEN_W{1'b0}} : r_len;
    assign w_len64     = 64'(r_len);

`ifdef SHA256_MSG_CTRL_ERR_EN
    logic w_len_ovf;
    logic r_err;
    assign {w_len_ovf, w_len_nxt} = {1'b0, w_len_base} + {{(LEN_W - 3){1'b0}}, 4'd8};
`else
    assign w_len_nxt = w_len_base + {{(LEN_W - 4){1'b0}}, 4'd8};
`endif

    assign busy      = w_run ? (r_pend || !w_in_absorb) : r_rst_sync[0];
    assign blk_valid = w_bv;
    assign blk_word  = w_blk_word;
    assign blk_first = w_bv && r_first;
    assign blk_last  = w_bv && (r_state == LEN_LO);

    // Word presented to the core in each state.
    always_comb begin
        w_blk_word = 32'h0;
        case (r_state)
            ABSORB: begin
                if (r_pend) w_blk_word = r_word;
                else        w_blk_word = 32'h0;
            end
            PAD: begin
                if (r_pend)       w_blk_word = r_word;
                else if (r_pad80) w_blk_word = 32'h0;
                else              w_blk_word = {PAD_BYTE, 24'h0};
            end
            LEN_HI:  w_blk_word = w_len64[63:32];
            LEN_LO:  w_blk_word = w_len64[31:0];
            default: w_blk_word = 32'h0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)     w_state_nxt = last ? PAD : ABSORB;
                else if (w_empty) w_state_nxt = PAD;
                else              w_state_nxt = IDLE;
            end
            ABSORB: begin
                if (w_accept && last) w_state_nxt = PAD;
                else                  w_state_nxt = ABSORB;
            end
            PAD: begin
                if (w_xfer && (r_widx == 4'(LEN_WORD_IDX - 1)) && w_pad80_nxt) w_state_nxt = LEN_HI;
                else                                                          w_state_nxt = PAD;
            end
            LEN_HI: begin
                if (w_xfer) w_state_nxt = LEN_LO;
                else        w_state_nxt = LEN_HI;
            end
            LEN_LO: begin
                if (w_xfer) w_state_nxt = WAIT_DIG;
                else        w_state_nxt = LEN_LO;
            end
            WAIT_DIG: begin
                if (w_load) w_state_nxt = OUT;
                else        w_state_nxt = WAIT_DIG;
            end
            OUT: begin
                if (w_ser_last) w_state_nxt = IDLE;
                else            w_state_nxt = OUT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Packing register, word index, first-block flag and bit-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= 32'h0;
            r_bpos  <= 2'd0;
            r_pend  <= 1'b0;
            r_pad80 <= 1'b0;
            r_first <= 1'b0;
            r_widx  <= 4'd0;
            r_len   <= {LEN_W{1'b0}};
        end else if (w_accept) begin
            r_len   <= w_len_nxt;
            r_first <= r_first || (r_state == IDLE);
            if (last) begin
                r_pend <= 1'b1;
                r_bpos <= 2'd0;
                if (r_bpos == 2'd3) begin
                    r_word  <= w_packed;
                    r_pad80 <= 1'b0;
                end else begin
                    r_word  <= put_byte(w_packed, PAD_BYTE, r_bpos + 2'd1);
                    r_pad80 <= 1'b1;
                end
            end else if (r_bpos == 2'd3) begin
                r_word <= w_packed;
                r_pend <= 1'b1;
                r_bpos <= 2'd0;
            end else begin
                r_word <= w_packed;
                r_bpos <= r_bpos + 2'd1;
            end
        end else if (w_empty) begin
            r_word  <= {PAD_BYTE, 24'h0};
            r_pend  <= 1'b1;
            r_pad80 <= 1'b1;
            r_bpos  <= 2'd0;
            r_first <= 1'b1;
            r_len   <= {LEN_W{1'b0}};
        end else if (w_xfer) begin
            r_pend <= 1'b0;
            r_widx <= r_widx + 4'd1;
            if (r_widx == 4'(BLOCK_WORDS - 1)) r_first <= 1'b0;
            if (r_state == PAD) r_pad80 <= w_pad80_nxt;
        end else begin
            r_pend <= r_pend;
        end
    end

`ifdef SHA256_MSG_CTRL_ERR_EN
    // Sticky error: bytes pushed during digest phases, or length overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_err <= 1'b0;
        end else if ((valid && busy && ((r_state == WAIT_DIG) || (r_state == OUT))) ||
                     (w_accept && w_len_ovf)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end
    assign err = r_err;
`endif

    sha256_digest_ser u_ser (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_load   (w_load),
        .i_digest (core_digest),
        .o_dout   (dout),
        .o_dvalid (dvalid),
        .o_last   (w_ser_last)
    );

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Self-checking bench for sha256_msg_ctrl: directed scenarios plus random messages against a padding model.
module tb_sha256_msg_ctrl;

    localparam int LEN_W = 32;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         rst_n, valid, last, blk_ready, core_done;
    logic [7:0]   din;
    logic [255:0] core_digest;
    logic         busy, blk_valid, blk_first, blk_last, dvalid;
    logic [31:0]  blk_word;
    logic [7:0]   dout;
`ifdef SHA256_MSG_CTRL_ERR_EN
    logic         err;
`endif

    int           errors = 0;
    int           checks = 0;
    int           ready_mode = 0;
    logic [33:0]  mon_w[$];
    logic [7:0]   mon_d[$];
    logic [7:0]   msg_q[$];
    logic [33:0]  exp_w[$];
    logic [255:0] dig;

    always #5 clk = ~clk;

    sha256_msg_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .valid(valid), .last(last), .busy(busy),
        .blk_word(blk_word), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_first(blk_first), .blk_last(blk_last), .core_done(core_done),
        .core_digest(core_digest), .dout(dout), .dvalid(dvalid)
`ifdef SHA256_MSG_CTRL_ERR_EN
        , .err(err)
`endif
    );

    // Core-side ready: random, forced high or forced low.
    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       blk_ready = 1'b1;
                2:       blk_ready = 1'b0;
                default: blk_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    // Monitor word transfers and digest bytes mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && blk_valid && blk_ready) mon_w.push_back({blk_first, blk_last, blk_word});
            if (dvalid) mon_d.push_back(dout);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] mw(input int i);
        if (i < mon_w.size()) return mon_w[i];
        return 34'h0;
    endfunction

    // Reference: standard SHA-256 padding of the byte message, then split into words.
    task automatic build_exp();
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          n;
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg_q.size()) * 64'd8;
        bits = bits & ((64'd1 << LEN_W) - 64'd1);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        n = p.size() / 4;
        exp_w.delete();
        for (int w = 0; w < n; w++)
            exp_w.push_back({(w < 16), (w == n - 1), p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int n;
        din = b; valid = 1'b1; last = l; n = 0;
        while (busy !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("accept_bound", 64'(n < 2000), 64'd1);
        @(posedge clk); #1;
        valid = 1'b0; last = 1'b0; din = 8'h00;
    endtask

    task automatic send_words(input string tag);
        int n;
        build_exp();
        mon_w.delete();
        if (msg_q.size() == 0) begin
            last = 1'b1; valid = 1'b0;
            @(posedge clk); #1;
            last = 1'b0;
        end else begin
            foreach (msg_q[i]) send_byte(msg_q[i], (i == msg_q.size() - 1));
        end
        n = 0;
        while (mon_w.size() < exp_w.size() && n < 4000) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_nwords"}, 64'(mon_w.size()), 64'(exp_w.size()));
        chk({tag, "_wait_state"}, {62'd0, blk_valid, busy}, 64'd1);
        for (int i = 0; i < exp_w.size(); i++)
            if (i < mon_w.size()) chk($sformatf("%s_w%0d", tag, i), 64'(mon_w[i]), 64'(exp_w[i]));
    endtask

    task automatic digest_out(input string tag, input logic [255:0] d);
        int n;
        mon_d.delete();
        core_digest = d; core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        n = 0;
        while (dvalid === 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        chk({tag, "_dvalid_run"}, 64'(n), 64'd32);
        chk({tag, "_idle_after"}, {62'd0, busy, dvalid}, 64'd0);
        chk({tag, "_nbytes"}, 64'(mon_d.size()), 64'd32);
        for (int k = 0; k < 32; k++)
            if (k < mon_d.size()) chk($sformatf("%s_d%0d", tag, k), 64'(mon_d[k]), 64'(d[255-8*k -: 8]));
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(255, 0)));
    endtask

    task automatic rand_dig(output logic [255:0] d);
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; last = 1'b0; din = 8'h00;
        core_done = 1'b0; core_digest = 256'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {58'd0, busy, blk_valid, blk_first, blk_last, dvalid, 1'b0}, 64'd0);
        chk("rst_words", {24'd0, blk_word, dout}, 64'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);

        core_done = 1'b1; core_digest = ABC_DIG;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(posedge clk); #1;
        chk("stray_done", {62'd0, dvalid, busy}, 64'd0);

        // "abc", with bytes offered during WAIT_DIG that must be ignored
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_words("abc");
        chk("abc_w0", 64'(mw(0)), {30'd0, 2'b10, 32'h61626380});
        chk("abc_w15", 64'(mw(15)), {30'd0, 2'b11, 32'h00000018});
        valid = 1'b1; last = 1'b1; din = 8'haa;
        repeat (3) begin
            @(posedge clk); #1;
            chk("wait_ignore", {62'd0, blk_valid, busy}, 64'd1);
        end
        valid = 1'b0; last = 1'b0;
        digest_out("abc", ABC_DIG);

        msg_q.delete();
        send_words("empty");
        chk("empty_w0", 64'(mw(0)), {30'd0, 2'b10, 32'h80000000});
        digest_out("empty", EMPTY_DIG);

        rand_msg(55);
        send_words("m55");
        chk("m55_w13_pad", 64'(mw(13) & 34'hff), 64'h80);
        chk("m55_lenlo", 64'(mw(15)), {30'd0, 2'b11, 32'h000001b8});
        rand_dig(dig);
        digest_out("m55", dig);

        rand_msg(56);
        send_words("m56");
        chk("m56_nw", 64'(mon_w.size()), 64'd32);
        chk("m56_lenlo", 64'(mw(31)), {30'd0, 2'b01, 32'h000001c0});
        chk("m56_b2w0", 64'(mw(16)), 64'd0);
        rand_dig(dig);
        digest_out("m56", dig);

        // Backpressure on word 3, with the next byte offered throughout
        ready_mode = 1;
        rand_msg(20);
        build_exp();
        mon_w.delete();
        for (int i = 0; i < 12; i++) send_byte(msg_q[i], 1'b0);
        @(posedge clk); #1;
        ready_mode = 2;
        for (int i = 12; i < 16; i++) send_byte(msg_q[i], 1'b0);
        din = msg_q[16]; valid = 1'b1;
        repeat (5) begin
            chk("stall_flags", {62'd0, blk_valid, busy}, 64'd3);
            chk("stall_word", 64'(blk_word), 64'(exp_w[3][31:0]));
            @(posedge clk); #1;
        end
        ready_mode = 1;
        for (int i = 16; i < 20; i++) send_byte(msg_q[i], (i == 19));
        repeat (40) @(posedge clk);
        #1;
        chk("stall_nwords", 64'(mon_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++)
            if (i < mon_w.size()) chk($sformatf("stall_w%0d", i), 64'(mon_w[i]), 64'(exp_w[i]));
        rand_dig(dig);
        digest_out("stall", dig);
        ready_mode = 0;

        // Reset during OUT at byte 10, then a fresh "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_words("abc2");
        dig = ABC_DIG;
        core_digest = dig; core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("out_byte10", 64'(dout), 64'(dig[255-80 -: 8]));
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {61'd0, dvalid, busy, blk_valid}, 64'd0);
        chk("abort_dout", 64'(dout), 64'd0);
        @(posedge clk); #1;
        chk("abort_hold", 64'(dvalid), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle", {62'd0, busy, dvalid}, 64'd0);
        send_words("abc3");
        digest_out("abc3", ABC_DIG);

        for (int t = 0; t < 6; t++) begin
            rand_msg($urandom_range(140, 0));
            send_words($sformatf("rnd%0d", t));
            rand_dig(dig);
            digest_out($sformatf("rnd%0d", t), dig);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
